buffer_fifo: RTL

BUFFER_FIFO -- requirements
Module: buffer_fifo

---
 rtl/buffer_fifo.sv | 100 ++++++++++
 1 files changed

// File: rtl/buffer_fifo.sv
// buffer_fifo: single-clock synchronous FIFO with a registered read port.
//
// A write lands at wr_ptr and a read returns the head entry on s one edge later.
// Pointers are $clog2(DEPTH) bits wide and wrap naturally because DEPTH is a
// power of two. The count register is the only occupancy state; full and empty
// are decoded from it.
//
// When full, a write is still accepted if a read is accepted in the same cycle.
// When empty, a read is ignored even if a write arrives in the same cycle.
//
// Optional build macro BUFFER_FIFO_FLAGS_EN adds sticky ovf/udf outputs.
// ovf records an ignored write and udf records an ignored read. Only rst clears them.

module buffer_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             p,
  input  logic                         wr_en,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             s,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef BUFFER_FIFO_FLAGS_EN
  ,
  output logic                         ovf,
  output logic                         udf
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             rd_ok;
  logic             wr_ok;

  // Flags come straight from the registered count, so they carry no extra state.
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // A read needs data present. A write needs room, or a slot freed by this cycle's read.
  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_ok);

  // Storage array: written on an accepted write.
  // NOTE: the array has no reset on purpose. Stale entries are unreachable once
  // the pointers and count are cleared, and leaving out the reset lets the
  // array map onto RAM.
  always_ff @(posedge clk) begin
    if (wr_ok && !rst) begin
      mem[wr_ptr] <= p;
    end
  end

  // Pointers, count and read data register. Reset takes priority over both requests.
  // NOTE: use non-blocking assignments only. Every register must then see
  // pre-edge values, so the read of mem and the count update are not affected
  // by a write in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      s      <= '0;
    end else begin
      if (rd_ok) begin
        s      <= mem[rd_ptr];
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (wr_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (wr_ok && !rd_ok) begin
        count <= count + CW'(1);
      end else if (rd_ok && !wr_ok) begin
        count <= count - CW'(1);
      end
    end
  end

`ifdef BUFFER_FIFO_FLAGS_EN
  // Sticky error flags. Each one is set by an ignored request and cleared only by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (wr_en && !wr_ok) ovf <= 1'b1;
      if (rd_en && empty)  udf <= 1'b1;
    end
  end
`endif

endmodule
